delay_timer_arbiter: RTL

Shares one millisecond-tick timer chain (ms timer plus decade counters) between two LCD-side requesters, such as the power-on init sequencer and the command/data writer. Each requester asks for a delay of N milliseconds. The block grants the timer round-robin, clears and enables it, counts ms ticks, and returns a one-cycle done pulse. It sits between the LCD control FSMs and the shared timer instance.

---
 rtl/lcd_timer_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/delay_timer_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lcd_timer_pkg.sv
// Shared definitions for the LCD timer-sharing logic: FSM state
// encoding, default delay width and requester index constants.
package lcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 10;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. The pick itself is combinational; the
// last-grant flag is only updated when the caller accepts the pick.
module rr_arbiter2
    import lcd_timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_en,
    output logic o_valid,
    output logic o_pick
);

    logic r_last;
    logic w_pick;

    // On a tie, favour the requester that was not granted last.
    always_comb begin
        w_pick = REQ0;
        if (i_req0 && i_req1) begin
            w_pick = ~r_last;
        end else if (i_req1) begin
            w_pick = REQ1;
        end
    end

    // Remember the accepted grant; reset value of 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= REQ1;
        end else if (i_en) begin
            r_last <= w_pick;
        end
    end

    assign o_valid = i_req0 | i_req1;
    assign o_pick  = w_pick;

endmodule

// File: rtl/delay_timer_arbiter.sv
// Grants a shared millisecond timer chain to one of two requesters,
// clears and enables it, counts ms ticks and pulses done at the end.
// All outputs are registered alongside the state.
module delay_timer_arbiter
    import lcd_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [CNT_W-1:0] dly0,
    input  logic             req1,
    input  logic [CNT_W-1:0] dly1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             tmr_rst,
    output logic             tmr_en,
    input  logic             ms_tick
);

    state_t           r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_remaining;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic             r_tmr_rst;
    logic             r_tmr_en;

    logic             w_valid;
    logic             w_pick;
    logic             w_arb_en;
    logic             w_owner_req;

    assign w_arb_en    = (r_state == ST_IDLE) && w_valid;
    assign w_owner_req = (r_owner == REQ1) ? req1 : req0;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_en    (w_arb_en),
        .o_valid (w_valid),
        .o_pick  (w_pick)
    );

    // Sequencing FSM; outputs are set for the state being entered so they
    // line up with r_state in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= REQ0;
            r_remaining <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_busy      <= 1'b0;
            r_tmr_rst   <= 1'b0;
            r_tmr_en    <= 1'b0;
        end else begin
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_tmr_rst <= 1'b0;
            r_tmr_en  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner     <= w_pick;
                        r_remaining <= (w_pick == REQ1) ? dly1 : dly0;
                        r_state     <= ST_START;
                        r_gnt0      <= (w_pick == REQ0);
                        r_gnt1      <= (w_pick == REQ1);
                        r_busy      <= 1'b1;
                        r_tmr_rst   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (!w_owner_req) begin
                        r_state <= ST_IDLE;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_remaining == '0) begin
                        r_state <= ST_DONE;
                        r_done0 <= (r_owner == REQ0);
                        r_done1 <= (r_owner == REQ1);
                    end else begin
                        r_state  <= ST_RUN;
                        r_tmr_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_owner_req) begin
                        r_state <= ST_IDLE;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (ms_tick) begin
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_done0 <= (r_owner == REQ0);
                            r_done1 <= (r_owner == REQ1);
                        end else begin
                            r_tmr_en <= 1'b1;
                        end
                    end else begin
                        r_tmr_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign busy    = r_busy;
    assign tmr_rst = r_tmr_rst;
    assign tmr_en  = r_tmr_en;

endmodule
